ccmult_stream: RTL and testbench



---
 rtl/ccmult_stream.sv | 114 +++++++++++
 tb/tb_ccmult_stream.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccmult_stream.sv
// rtl/ccmult_stream.sv - 4-stage streaming complex multiplier a*b / a*conj(b) with valid/ready backpressure
// Optional output saturation: define CCMULT_SAT_EN (otherwise two's-complement wrap, ovf tied 0).
module ccmult_stream #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] ar,
    input  logic signed [DATA_W-1:0] ai,
    input  logic signed [DATA_W-1:0] br,
    input  logic signed [DATA_W-1:0] bi,
    input  logic                     conj_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] pr,
    output logic signed [DATA_W-1:0] pi,
    output logic                     ovf
);
    localparam int PW = 2 * DATA_W + 1;
    localparam int SW = 2 * DATA_W + 2;
    localparam logic signed [SW-1:0] HALF = {{(SW-1){1'b0}}, 1'b1} << (FRAC_W - 1);

    logic                     w_adv;
    logic signed [DATA_W:0]   w_bi_ext;
    logic signed [DATA_W:0]   w_bi_c;
    logic signed [PW-1:0]     w_p_rr, w_p_ii, w_p_ri, w_p_ir;
    logic signed [SW-1:0]     w_re_rnd, w_im_rnd;
    logic signed [DATA_W-1:0] w_pr_n, w_pi_n;
    logic                     w_ovf_n;

    logic                     r_v1, r_v2, r_v3;
    logic signed [PW-1:0]     r_p_rr, r_p_ii, r_p_ri, r_p_ir;
    logic signed [SW-1:0]     r_re, r_im;
    logic signed [SW-1:0]     r_sc_re, r_sc_im;

    // The whole pipeline moves as one; a stalled output freezes every stage, bubbles included.
    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

    // One extra bit so that negating the most negative bi cannot wrap.
    assign w_bi_ext = {bi[DATA_W-1], bi};
    assign w_bi_c   = conj_b ? -w_bi_ext : w_bi_ext;

    assign w_p_rr = ar * br;
    assign w_p_ii = ai * w_bi_c;
    assign w_p_ri = ar * w_bi_c;
    assign w_p_ir = ai * br;

    assign w_re_rnd = r_re + HALF;
    assign w_im_rnd = r_im + HALF;

`ifdef CCMULT_SAT_EN
    localparam logic signed [DATA_W-1:0] MAXV = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] MINV = {1'b1, {(DATA_W-1){1'b0}}};
    logic w_re_fit, w_im_fit;

    // A value fits when every bit from the result sign upwards agrees.
    assign w_re_fit = (&r_sc_re[SW-1:DATA_W-1]) || !(|r_sc_re[SW-1:DATA_W-1]);
    assign w_im_fit = (&r_sc_im[SW-1:DATA_W-1]) || !(|r_sc_im[SW-1:DATA_W-1]);
    assign w_pr_n   = w_re_fit ? r_sc_re[DATA_W-1:0] : (r_sc_re[SW-1] ? MINV : MAXV);
    assign w_pi_n   = w_im_fit ? r_sc_im[DATA_W-1:0] : (r_sc_im[SW-1] ? MINV : MAXV);
    assign w_ovf_n  = !w_re_fit || !w_im_fit;
`else
    logic w_unused_hi;

    assign w_unused_hi = ^{r_sc_re[SW-1:DATA_W], r_sc_im[SW-1:DATA_W]};
    assign w_pr_n      = r_sc_re[DATA_W-1:0];
    assign w_pi_n      = r_sc_im[DATA_W-1:0];
    assign w_ovf_n     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1      <= 1'b0;
            r_v2      <= 1'b0;
            r_v3      <= 1'b0;
            out_valid <= 1'b0;
            r_p_rr    <= '0;
            r_p_ii    <= '0;
            r_p_ri    <= '0;
            r_p_ir    <= '0;
            r_re      <= '0;
            r_im      <= '0;
            r_sc_re   <= '0;
            r_sc_im   <= '0;
            pr        <= '0;
            pi        <= '0;
            ovf       <= 1'b0;
        end else if (w_adv) begin
            r_v1      <= in_valid;
            r_p_rr    <= w_p_rr;
            r_p_ii    <= w_p_ii;
            r_p_ri    <= w_p_ri;
            r_p_ir    <= w_p_ir;

            r_v2      <= r_v1;
            r_re      <= {r_p_rr[PW-1], r_p_rr} - {r_p_ii[PW-1], r_p_ii};
            r_im      <= {r_p_ri[PW-1], r_p_ri} + {r_p_ir[PW-1], r_p_ir};

            r_v3      <= r_v2;
            r_sc_re   <= w_re_rnd >>> FRAC_W;
            r_sc_im   <= w_im_rnd >>> FRAC_W;

            out_valid <= r_v3;
            pr        <= w_pr_n;
            pi        <= w_pi_n;
            ovf       <= w_ovf_n;
        end
    end

endmodule

// File: tb/tb_ccmult_stream.sv
// tb/tb_ccmult_stream.sv - scoreboard bench for ccmult_stream (DATA_W=16, FRAC_W=8)
module tb_ccmult_stream;
    localparam int DW = 16;
    localparam int FW = 8;
`ifdef CCMULT_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct packed {
        logic        ovf;
        logic [15:0] pr;
        logic [15:0] pi;
    } exp_t;

    logic clk, rst_n, in_valid, in_ready, conj_b, out_valid, out_ready, ovf;
    logic signed [DW-1:0] ar, ai, br, bi, pr, pi;

    exp_t sb[$];
    exp_t e_mon, g_mon;
    int n_cmp = 0;
    int n_bad = 0;
    int n_outs = 0;

    ccmult_stream #(.DATA_W(DW), .FRAC_W(FW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .ar(ar), .ai(ai), .br(br), .bi(bi), .conj_b(conj_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .pr(pr), .pi(pi), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(int a_r, int a_i, int b_r, int b_i, bit cj);
        longint bip, re, im;
        exp_t e;
        bip = cj ? -longint'(b_i) : longint'(b_i);
        re  = longint'(a_r) * b_r - longint'(a_i) * bip;
        im  = longint'(a_r) * bip + longint'(a_i) * b_r;
        re  = (re + (longint'(1) << (FW - 1))) >>> FW;
        im  = (im + (longint'(1) << (FW - 1))) >>> FW;
        e.ovf = 1'b0;
        if (SAT) begin
            if (re > 32767)  begin re = 32767;  e.ovf = 1'b1; end
            if (re < -32768) begin re = -32768; e.ovf = 1'b1; end
            if (im > 32767)  begin im = 32767;  e.ovf = 1'b1; end
            if (im < -32768) begin im = -32768; e.ovf = 1'b1; end
        end
        e.pr = re[15:0];
        e.pi = im[15:0];
        return e;
    endfunction

    // Scoreboard: expectation pushed on every input transfer, popped on every output transfer.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_outs++;
                n_cmp++;
                g_mon = {ovf, pr, pi};
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL sb_unexpected: got pr=%0d pi=%0d ovf=%0d, expected no output", pr, pi, ovf);
                end else begin
                    e_mon = sb.pop_front();
                    if (g_mon !== e_mon) begin
                        n_bad++;
                        $display("FAIL sb_result: got pr=%0d pi=%0d ovf=%0d, expected pr=%0d pi=%0d ovf=%0d",
                                 pr, pi, ovf, $signed(e_mon.pr), $signed(e_mon.pi), e_mon.ovf);
                    end
                end
            end
            if (in_valid && in_ready)
                sb.push_back(model(int'(ar), int'(ai), int'(br), int'(bi), conj_b));
        end
    end

    task automatic send_one(input int a_r, input int a_i, input int b_r, input int b_i, input bit cj,
                            output logic signed [DW-1:0] o_pr, output logic signed [DW-1:0] o_pi,
                            output logic o_ovf, output int lat);
        @(posedge clk); #1;
        ar = 16'(a_r); ai = 16'(a_i); br = 16'(b_r); bi = 16'(b_i); conj_b = cj; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
        o_pr = pr; o_pi = pi; o_ovf = ovf;
    endtask

    task automatic drain(output int left);
        for (int k = 0; k < 40 && sb.size() != 0; k++) @(posedge clk);
        repeat (2) @(posedge clk);
        left = sb.size();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; conj_b = 1'b0;
        ar = '0; ai = '0; br = '0; bi = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %0d expected 0", out_valid); end
        n_cmp++; if (pr !== 16'sd0) begin n_bad++; $display("FAIL reset_pr: got %0d expected 0", pr); end
        n_cmp++; if (pi !== 16'sd0) begin n_bad++; $display("FAIL reset_pi: got %0d expected 0", pi); end
        n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %0d expected 0", ovf); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %0d expected 1", in_ready); end
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
    endtask

    task automatic test_latency();
        logic signed [DW-1:0] o_pr, o_pi;
        logic o_ovf;
        int lat;
        send_one(256, 512, 768, -256, 1'b0, o_pr, o_pi, o_ovf, lat);
        n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL latency: got %0d edges expected 4", lat); end
        n_cmp++; if (o_pr !== 16'sd1280) begin n_bad++; $display("FAIL latency_pr: got %0d expected 1280", o_pr); end
        n_cmp++; if (o_pi !== 16'sd1280) begin n_bad++; $display("FAIL latency_pi: got %0d expected 1280", o_pi); end
        n_cmp++; if (o_ovf !== 1'b0) begin n_bad++; $display("FAIL latency_ovf: got %0d expected 0", o_ovf); end
        @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL latency_single_pulse: got %0d expected 0", out_valid); end
    endtask

    task automatic test_conj();
        logic signed [DW-1:0] o_pr, o_pi;
        logic o_ovf;
        int lat;
        send_one(256, 512, 768, -256, 1'b1, o_pr, o_pi, o_ovf, lat);
        n_cmp++; if (o_pr !== 16'sd256) begin n_bad++; $display("FAIL conj_pr: got %0d expected 256", o_pr); end
        n_cmp++; if (o_pi !== 16'sd1792) begin n_bad++; $display("FAIL conj_pi: got %0d expected 1792", o_pi); end
    endtask

    task automatic test_rounding();
        logic signed [DW-1:0] o_pr, o_pi;
        logic o_ovf;
        int lat;
        send_one(1, 0, 128, 0, 1'b0, o_pr, o_pi, o_ovf, lat);
        n_cmp++; if (o_pr !== 16'sd1 || o_pi !== 16'sd0) begin n_bad++; $display("FAIL round_half_pos: got pr=%0d pi=%0d expected pr=1 pi=0", o_pr, o_pi); end
        send_one(-1, 0, 128, 0, 1'b0, o_pr, o_pi, o_ovf, lat);
        n_cmp++; if (o_pr !== 16'sd0) begin n_bad++; $display("FAIL round_half_neg: got %0d expected 0", o_pr); end
        send_one(-1, 0, 129, 0, 1'b0, o_pr, o_pi, o_ovf, lat);
        n_cmp++; if (o_pr !== -16'sd1) begin n_bad++; $display("FAIL round_below_half_neg: got %0d expected -1", o_pr); end
    endtask

    task automatic test_saturation();
        logic signed [DW-1:0] o_pr, o_pi, x_pr, x_pi;
        logic o_ovf, x_ovf;
        int lat;
        send_one(32767, 0, 32767, 0, 1'b0, o_pr, o_pi, o_ovf, lat);
        x_pr = SAT ? 16'sd32767 : -16'sd256; x_ovf = SAT;
        n_cmp++; if (o_pr !== x_pr || o_pi !== 16'sd0 || o_ovf !== x_ovf) begin n_bad++;
            $display("FAIL sat_max_sq: got pr=%0d pi=%0d ovf=%0d expected pr=%0d pi=0 ovf=%0d", o_pr, o_pi, o_ovf, x_pr, x_ovf); end
        send_one(-32768, 0, 0, -32768, 1'b0, o_pr, o_pi, o_ovf, lat);
        x_pi = SAT ? 16'sd32767 : 16'sd0;
        n_cmp++; if (o_pi !== x_pi || o_pr !== 16'sd0 || o_ovf !== x_ovf) begin n_bad++;
            $display("FAIL sat_min_pos: got pr=%0d pi=%0d ovf=%0d expected pr=0 pi=%0d ovf=%0d", o_pr, o_pi, o_ovf, x_pi, x_ovf); end
        send_one(-32768, 0, 0, -32768, 1'b1, o_pr, o_pi, o_ovf, lat);
        x_pi = SAT ? -16'sd32768 : 16'sd0;
        n_cmp++; if (o_pi !== x_pi || o_pr !== 16'sd0 || o_ovf !== x_ovf) begin n_bad++;
            $display("FAIL sat_min_conj: got pr=%0d pi=%0d ovf=%0d expected pr=0 pi=%0d ovf=%0d", o_pr, o_pi, o_ovf, x_pi, x_ovf); end
        send_one(256, 0, 0, -32768, 1'b1, o_pr, o_pi, o_ovf, lat);
        x_pi = SAT ? 16'sd32767 : -16'sd32768;
        n_cmp++; if (o_pi !== x_pi || o_ovf !== x_ovf) begin n_bad++;
            $display("FAIL conj_neg_min: got pi=%0d ovf=%0d expected pi=%0d ovf=%0d", o_pi, o_ovf, x_pi, x_ovf); end
    endtask

    task automatic test_backpressure();
        int outs0, left;
        outs0 = n_outs;
        fork
            begin
                bit took;
                @(posedge clk); #1;
                for (int i = 0; i < 6; i++) begin
                    ar = 16'($urandom_range(0, 65535)); ai = 16'($urandom_range(0, 65535));
                    br = 16'($urandom_range(0, 65535)); bi = 16'($urandom_range(0, 65535));
                    conj_b = i[0]; in_valid = 1'b1;
                    took = 1'b0;
                    for (int k = 0; k < 20 && !took; k++) begin
                        @(negedge clk); took = in_ready;
                        @(posedge clk); #1;
                    end
                end
                in_valid = 1'b0;
            end
            begin
                bit seen;
                logic signed [DW-1:0] h_pr, h_pi;
                logic h_ovf;
                seen = 1'b0;
                for (int k = 0; k < 30 && !seen; k++) begin
                    @(negedge clk); seen = out_valid;
                end
                n_cmp++; if (!seen) begin n_bad++; $display("FAIL bp_first_out: got no out_valid expected within 30 cycles"); end
                @(posedge clk); #1;
                out_ready = 1'b0;
                @(negedge clk);
                h_pr = pr; h_pi = pi; h_ovf = ovf;
                n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready: got %0d expected 0", in_ready); end
                for (int k = 0; k < 2; k++) begin
                    @(posedge clk); @(negedge clk);
                    n_cmp++; if ({out_valid, pr, pi, ovf} !== {1'b1, h_pr, h_pi, h_ovf}) begin n_bad++;
                        $display("FAIL bp_hold: got v=%0d pr=%0d pi=%0d ovf=%0d expected v=1 pr=%0d pi=%0d ovf=%0d",
                                 out_valid, pr, pi, ovf, h_pr, h_pi, h_ovf); end
                    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready_hold: got %0d expected 0", in_ready); end
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain(left);
        n_cmp++; if (left !== 0) begin n_bad++; $display("FAIL bp_drain: got %0d pending expected 0", left); end
        n_cmp++; if (n_outs - outs0 !== 6) begin n_bad++; $display("FAIL bp_count: got %0d outputs expected 6", n_outs - outs0); end
    endtask

    task automatic test_reset_midstream();
        logic signed [DW-1:0] o_pr, o_pi;
        logic o_ovf;
        int lat;
        bit stale;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            ar = 16'sd256; ai = 16'(512 + i); br = 16'sd768; bi = -16'sd256; conj_b = 1'b0; in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || pr !== 16'sd1280) begin n_bad++;
            $display("FAIL mid_pre_reset: got v=%0d pr=%0d expected v=1 pr=1280", out_valid, pr); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({out_valid, pr, pi, ovf} !== 34'd0) begin n_bad++;
            $display("FAIL mid_async_clear: got v=%0d pr=%0d pi=%0d ovf=%0d expected all 0", out_valid, pr, pi, ovf); end
        sb.delete();
        #3 rst_n = 1'b1;
        stale = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (out_valid) stale = 1'b1;
        end
        n_cmp++; if (stale !== 1'b0) begin n_bad++; $display("FAIL mid_stale: got stale output expected none"); end
        send_one(256, 512, 768, -256, 1'b1, o_pr, o_pi, o_ovf, lat);
        n_cmp++; if (lat !== 4 || o_pr !== 16'sd256 || o_pi !== 16'sd1792) begin n_bad++;
            $display("FAIL mid_recover: got lat=%0d pr=%0d pi=%0d expected lat=4 pr=256 pi=1792", lat, o_pr, o_pi); end
    endtask

    initial begin
        int left;
        test_reset();
        test_latency();
        test_conj();
        test_rounding();
        test_saturation();
        drain(left);
        n_cmp++; if (left !== 0) begin n_bad++; $display("FAIL directed_drain: got %0d pending expected 0", left); end
        test_backpressure();
        test_reset_midstream();
        drain(left);
        n_cmp++; if (left !== 0) begin n_bad++; $display("FAIL final_drain: got %0d pending expected 0", left); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
